// File: rtl/o_feature_accum.sv
// rtl/o_feature_accum.sv - multi-pass output-channel accumulator with saturating drain stream
module o_feature_accum #(
  parameter int FEATURE_WIDTH = 16,
  parameter int ACC_WIDTH     = 24,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [7:0]                      pass_num,
  input  logic [ADDR_WIDTH:0]             entry_num,
  input  logic                            relu_en,
  input  logic                            in_valid,
  input  logic signed [FEATURE_WIDTH-1:0] in_data,
  output logic                            busy,
  output logic                            done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [FEATURE_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]           out_addr
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t                        state;
  logic [ADDR_WIDTH-1:0]         entry_idx;
  logic [ADDR_WIDTH-1:0]         last_entry;
  logic [7:0]                    pass_idx;
  logic [7:0]                    last_pass;
  logic                          relu_q;
  logic signed [ACC_WIDTH-1:0]   buf_mem [DEPTH];
  logic signed [ACC_WIDTH-1:0]   in_ext;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic                          acc_we;
  logic [ADDR_WIDTH-1:0]         rd_addr;
  logic signed [FEATURE_WIDTH-1:0] drain_val;

  // Add two accumulator values, clamping to the signed ACC_WIDTH range on overflow.
  function automatic logic signed [ACC_WIDTH-1:0] sat_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      sat_add = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      sat_add = s[ACC_WIDTH-1:0];
  endfunction

  // Narrow an accumulator to the feature range; ReLU is applied after saturation.
  function automatic logic signed [FEATURE_WIDTH-1:0] to_out(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic                        relu
  );
    logic signed [FEATURE_WIDTH-1:0] r;
    if ((&acc[ACC_WIDTH-1:FEATURE_WIDTH-1]) || !(|acc[ACC_WIDTH-1:FEATURE_WIDTH-1]))
      r = acc[FEATURE_WIDTH-1:0];
    else
      r = acc[ACC_WIDTH-1] ? {1'b1, {(FEATURE_WIDTH-1){1'b0}}} : {1'b0, {(FEATURE_WIDTH-1){1'b1}}};
    if (relu && r[FEATURE_WIDTH-1])
      r = '0;
    to_out = r;
  endfunction

  // Accumulate datapath and drain read-side selection (register array, combinational read).
  always_comb begin
    in_ext    = ACC_WIDTH'(in_data);
    acc_next  = (pass_idx == 8'd0) ? in_ext : sat_add(buf_mem[entry_idx], in_ext);
    acc_we    = (state == S_ACCUM) && in_valid;
    rd_addr   = out_valid ? out_addr + 1'b1 : '0;
    drain_val = to_out(buf_mem[rd_addr], relu_q);
  end

  // Buffer write; contents intentionally survive reset since pass 0 overwrites every used entry.
  always_ff @(posedge clk) begin
    if (!rst && acc_we)
      buf_mem[entry_idx] <= acc_next;
  end

  // Job control FSM with registered status and output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      entry_idx  <= '0;
      pass_idx   <= '0;
      last_entry <= '0;
      last_pass  <= '0;
      relu_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (entry_num == '0 || entry_num > (ADDR_WIDTH+1)'(DEPTH))
              last_entry <= ADDR_WIDTH'(DEPTH - 1);
            else
              last_entry <= ADDR_WIDTH'(entry_num - 1'b1);
            last_pass <= (pass_num == 8'd0) ? 8'd0 : pass_num - 8'd1;
            relu_q    <= relu_en;
            entry_idx <= '0;
            pass_idx  <= '0;
            busy      <= 1'b1;
            state     <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            if (entry_idx == last_entry) begin
              entry_idx <= '0;
              if (pass_idx == last_pass) begin
                pass_idx <= '0;
                state    <= S_DRAIN;
              end else begin
                pass_idx <= pass_idx + 8'd1;
              end
            end else begin
              entry_idx <= entry_idx + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!out_valid || out_ready) begin
            if (out_valid && out_addr == last_entry) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              out_valid <= 1'b1;
              out_data  <= drain_val;
              out_addr  <= rd_addr;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_o_feature_accum.sv
// tb/tb_o_feature_accum.sv - scoreboard bench for o_feature_accum
module tb_o_feature_accum;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  pass_num;
  logic [4:0]  entry_num;
  logic        relu_en;
  logic        in_valid;
  logic [15:0] in_data;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_addr;

  int checks = 0;
  int errors = 0;
  int stim_q[$];
  int exp_addr[$];
  int exp_data[$];
  int first_valid_cyc, last_xfer_cyc, done_cyc, valid_cycles;

  o_feature_accum #(
    .FEATURE_WIDTH(16), .ACC_WIDTH(24), .DEPTH(16), .ADDR_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pass_num(pass_num), .entry_num(entry_num),
    .relu_en(relu_en), .in_valid(in_valid), .in_data(in_data), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference model: computes expected stream from stim_q and pushes it to the scoreboard.
  task automatic model_job(input int p, input int e, input int relu);
    int acc[16];
    int ee, pp, o;
    ee = (e == 0 || e > 16) ? 16 : e;
    pp = (p == 0) ? 1 : p;
    for (int k = 0; k < pp * ee; k++) begin
      if (k / ee == 0) acc[k % ee] = stim_q[k];
      else acc[k % ee] = clampi(acc[k % ee] + stim_q[k], -(1 << 23), (1 << 23) - 1);
    end
    for (int i = 0; i < ee; i++) begin
      o = clampi(acc[i], -32768, 32767);
      if (relu != 0 && o < 0) o = 0;
      exp_addr.push_back(i);
      exp_data.push_back(o);
    end
  endtask

  task automatic start_job(input int p, input int e, input int r);
    start = 1'b1;
    pass_num = 8'(p);
    entry_num = 5'(e);
    relu_en = r[0];
    tick();
    start = 1'b0;
  endtask

  task automatic feed_from(input int first);
    for (int i = first; i < stim_q.size(); i++) begin
      in_valid = 1'b1;
      in_data = 16'(stim_q[i]);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int hold_low, input int alt);
    int cyc, seen, dcnt;
    logic held;
    logic [15:0] hd, ed;
    logic [3:0] ha;
    int ea;
    cyc = 0; seen = 0; dcnt = 0; held = 1'b0;
    first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1; valid_cycles = 0;
    while (cyc < 300 && !(exp_addr.size() == 0 && dcnt > 0)) begin
      if (!out_valid) out_ready = 1'b1;
      else if (seen < hold_low) out_ready = 1'b0;
      else if (alt != 0) out_ready = ((seen - hold_low) % 2) == 0;
      else out_ready = 1'b1;
      @(negedge clk);
      if (held) begin
        checks++;
        if (out_addr !== ha || out_data !== hd) begin
          errors++;
          $display("FAIL %s hold_stable: got (%0d,%h) want (%0d,%h)", name, out_addr, out_data, ha, hd);
        end
      end
      held = 1'b0;
      if (done) begin dcnt++; done_cyc = cyc; end
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        valid_cycles++;
        seen++;
        if (out_ready) begin
          checks++;
          if (exp_addr.size() == 0) begin
            errors++;
            $display("FAIL %s extra_output: got (%0d,%h) want none", name, out_addr, out_data);
          end else begin
            ea = exp_addr.pop_front();
            ed = 16'(exp_data.pop_front());
            if (out_addr !== 4'(ea) || out_data !== ed) begin
              errors++;
              $display("FAIL %s output: got (%0d,%0d) want (%0d,%0d)", name, out_addr,
                       $signed(out_data), ea, $signed(ed));
            end
          end
          last_xfer_cyc = cyc;
        end else begin
          held = 1'b1; ha = out_addr; hd = out_data;
        end
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc >= 300 || exp_addr.size() != 0) begin
      errors++;
      $display("FAIL %s drain_timeout: got %0d pending want 0", name, exp_addr.size());
      exp_addr.delete();
      exp_data.delete();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s post_idle: got done=%b valid=%b busy=%b want 0 0 0", name, done, out_valid, busy);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic run_job(input string name, input int p, input int e, input int r,
                         input int hold_low, input int alt);
    model_job(p, e, r);
    start_job(p, e, r);
    feed_from(0);
    drain(name, hold_low, alt);
    stim_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0 || out_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b valid=%b data=%h addr=%h want all 0",
               busy, done, out_valid, out_data, out_addr);
    end
    tick();
  endtask

  task automatic test_basic();
    stim_q = '{1, 2, 3, 4};
    run_job("basic", 1, 4, 0, 0, 0);
  endtask

  task automatic test_multipass_relu();
    stim_q = '{10, -5, 20, -5, 30, -5};
    run_job("multipass", 3, 2, 0, 0, 0);
    stim_q = '{10, -5, 20, -5, 30, -5};
    run_job("multipass_relu", 3, 2, 1, 0, 0);
  endtask

  task automatic test_saturation();
    stim_q = '{28672, 28672};
    run_job("sat_pos", 2, 1, 0, 0, 0);
    stim_q = '{-28672, -28672};
    run_job("sat_neg", 2, 1, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    stim_q = '{-100, 555, 32000};
    run_job("backpressure", 1, 3, 0, 3, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) stim_q.push_back(int'($urandom_range(0, 65535)) - 32768);
    run_job("throughput", 1, 16, 0, 0, 0);
    checks++;
    if (first_valid_cyc != 1 || valid_cycles != 16 || last_xfer_cyc != 16 || done_cyc != 17) begin
      errors++;
      $display("FAIL throughput_timing: got first=%0d count=%0d last=%0d done=%0d want 1 16 16 17",
               first_valid_cyc, valid_cycles, last_xfer_cyc, done_cyc);
    end
    for (int i = 0; i < 16; i++) stim_q.push_back(int'($urandom_range(0, 200)) - 100);
    run_job("clamp_zero_params", 0, 0, 1, 0, 0);
  endtask

  task automatic test_robustness();
    stim_q = '{7, 8, 9, 10};
    model_job(2, 2, 0);
    start_job(2, 2, 0);
    in_valid = 1'b1; in_data = 16'(stim_q[0]);
    start = 1'b1; pass_num = 8'd1; entry_num = 5'd1;
    tick();
    start = 1'b0;
    feed_from(1);
    drain("start_mid_accum", 0, 0);
    stim_q.delete();

    in_valid = 1'b1; in_data = 16'd999; out_ready = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_inputs: got busy=%b valid=%b want 0 0", busy, out_valid);
    end
    tick();
    stim_q = '{3, 4};
    run_job("after_idle_valid", 1, 2, 0, 0, 0);

    start_job(2, 2, 0);
    in_valid = 1'b1; in_data = 16'd100; tick();
    in_data = 16'd200; tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_accum: got busy=%b valid=%b want 0 0", busy, out_valid);
    end
    stim_q = '{7, 8};
    run_job("after_rst", 1, 2, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pass_num = '0; entry_num = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_multipass_relu();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_robustness();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
